// File: rtl/segment_sniff.sv
// Sniffs a multiplexed 7-segment display bus and turns each newly shown glyph into a character event.
// Latency: pins held from before edge 0 give o_valid after edge 3+STABLE (2 sync flops, change detect, count, capture).
// Backpressure: 4-deep FWFT event FIFO; a write into a full FIFO with no pop is dropped and o_ovf sticks high.
module segment_sniff #(
  parameter int DIGITS = 8,
  parameter int STABLE = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [6:0]                i_seg,
  input  logic [DIGITS-1:0]         i_an,
  output logic [7:0]                o_code,
  output logic [$clog2(DIGITS)-1:0] o_idx,
  output logic                      o_err,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame,
  output logic                      o_ovf
);

  localparam int IW = $clog2(DIGITS);
  localparam int SW = DIGITS + 7;
  localparam int EW = IW + 7;
  localparam logic [7:0] STB = 8'(STABLE);

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  logic [SW-1:0]     sync1, sync2, prev;
  logic              change;
  logic [7:0]        cnt;
  state_t            state, state_nxt;
  logic              capture;
  logic [DIGITS-1:0] an_low;
  logic              one_low;
  logic [IW-1:0]     cap_idx;
  logic [6:0]        seg_on;
  logic [5:0]        dec_code;
  logic              dec_err;
  logic              take;
  logic              wr;
  logic [DIGITS-1:0] seen;
  logic [5:0]        shadow [DIGITS];
  logic [DIGITS-1:0] mask;
  logic [DIGITS-1:0] cap_bit;
  logic              frame;
  logic              ovf;
  logic [EW-1:0]     mem [4];
  logic [EW-1:0]     head;
  logic [1:0]        rd_ptr, wr_ptr;
  logic [2:0]        count;
  logic              push, pop;

  // Two-flop synchronizer plus a one-cycle history used for change detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {i_an, i_seg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign change = (sync2 != prev);

  // Stability counter: restart on any line change, otherwise count up and saturate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 8'd0;
    end else if (change) begin
      cnt <= 8'd0;
    end else if (cnt != STB) begin
      cnt <= cnt + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_WAIT;
    else          state <= state_nxt;
  end

  // Capture once per stable period; prev holds the value that was stable, so a change
  // arriving in the capture cycle still captures the old glyph and re-arms WAIT.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (state == ST_WAIT && cnt == STB) begin
      capture   = 1'b1;
      state_nxt = ST_HOLD;
    end
    if (change) state_nxt = ST_WAIT;
  end

  assign an_low  = ~prev[SW-1:7];
  assign one_low = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);

  // Position of the active (low) digit enable.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_low[i]) cap_idx = IW'(i);
    end
  end

  assign seg_on = ~prev[6:0];

  // Inverse glyph table; shared shapes resolve to the digit code.
  always_comb begin
    dec_code = 6'h3F;
    dec_err  = 1'b0;
    case (seg_on)
      7'h3F: dec_code = 6'h00;
      7'h06: dec_code = 6'h01;
      7'h5B: dec_code = 6'h02;
      7'h4F: dec_code = 6'h03;
      7'h66: dec_code = 6'h04;
      7'h6D: dec_code = 6'h05;
      7'h7D: dec_code = 6'h06;
      7'h07: dec_code = 6'h07;
      7'h7F: dec_code = 6'h08;
      7'h6F: dec_code = 6'h09;
      7'h77: dec_code = 6'h0A;
      7'h7C: dec_code = 6'h0B;
      7'h39: dec_code = 6'h0C;
      7'h5E: dec_code = 6'h0D;
      7'h79: dec_code = 6'h0E;
      7'h71: dec_code = 6'h0F;
      7'h3D: dec_code = 6'h10;
      7'h76: dec_code = 6'h11;
      7'h1E: dec_code = 6'h13;
      7'h75: dec_code = 6'h14;
      7'h38: dec_code = 6'h15;
      7'h37: dec_code = 6'h16;
      7'h54: dec_code = 6'h17;
      7'h73: dec_code = 6'h19;
      7'h67: dec_code = 6'h1A;
      7'h50: dec_code = 6'h1B;
      7'h78: dec_code = 6'h1D;
      7'h3E: dec_code = 6'h1E;
      7'h1C: dec_code = 6'h1F;
      7'h2A: dec_code = 6'h20;
      7'h36: dec_code = 6'h21;
      7'h6E: dec_code = 6'h22;
      7'h40: dec_code = 6'h24;
      7'h00: dec_code = 6'h3E;
      default: begin
        dec_code = 6'h3F;
        dec_err  = 1'b1;
      end
    endcase
  end

  assign take = capture && one_low;
  assign wr   = take && (!seen[cap_idx] || (shadow[cap_idx] != dec_code));

  // Per-digit shadow of the last captured code; suppresses repeats of a static display.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seen <= '0;
      for (int i = 0; i < DIGITS; i++) shadow[i] <= 6'd0;
    end else if (take) begin
      seen[cap_idx]   <= 1'b1;
      shadow[cap_idx] <= dec_code;
    end
  end

  assign cap_bit = take ? (DIGITS'(1) << cap_idx) : '0;

  // Frame mask: pulse o_frame the cycle after every digit has been captured, then restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask  <= '0;
      frame <= 1'b0;
    end else if (&mask) begin
      mask  <= cap_bit;
      frame <= 1'b1;
    end else begin
      mask  <= mask | cap_bit;
      frame <= 1'b0;
    end
  end

  assign o_valid = (count != 3'd0);
  assign pop     = o_valid && i_ready;
  assign push    = wr && ((count != 3'd4) || pop);

  // Event storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {cap_idx, dec_code, dec_err};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (wr && count == 3'd4 && !pop) ovf <= 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign o_idx   = o_valid ? head[EW-1 -: IW] : '0;
  assign o_code  = o_valid ? {2'b00, head[6:1]} : 8'h00;
  assign o_err   = o_valid & head[0];
  assign o_frame = frame;
  assign o_ovf   = ovf;

endmodule

// File: tb/tb_segment_sniff.sv
// Bench for segment_sniff: scoreboard of expected events checked on every FIFO pop.
// Directed timing, decode, frame, glitch, overflow and mid-run reset scenarios.
// Consumer readiness is driven by the stimulus to exercise stall and drain.
module tb_segment_sniff;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic [7:0]        code;
  logic [2:0]        idx;
  logic              err, valid, ready, frame, ovf;

  always #5 clk = ~clk;

  segment_sniff #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_seg   (seg),
    .i_an    (an),
    .o_code  (code),
    .o_idx   (idx),
    .o_err   (err),
    .o_valid (valid),
    .i_ready (ready),
    .o_frame (frame),
    .o_ovf   (ovf)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] code;
    logic       err;
  } ev_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ev_cnt = 0;
  int   frame_cnt = 0;
  ev_t  q[$];
  ev_t  mon_e;
  logic m_seen [DIGITS];
  logic [7:0] m_shadow [DIGITS];

  // Forward glyph table (segments lit, bit0 = top), indexed by character code.
  logic [6:0] glyph [0:36] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E,
    7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
    7'h3E, 7'h1C, 7'h2A, 7'h36, 7'h6E, 7'h5B, 7'h40
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Reference decode: first code whose glyph matches, so digits win shared shapes.
  function automatic logic [8:0] m_decode(input logic [6:0] s);
    logic [6:0] on;
    on = ~s;
    if (on == 7'h00) return {1'b0, 8'h3E};
    for (int c = 0; c < 37; c++) begin
      if (glyph[c] == on) return {1'b0, 8'(c)};
    end
    return {1'b1, 8'h3F};
  endfunction

  function automatic logic [DIGITS-1:0] an_for(input int d);
    return ~(DIGITS'(1) << d);
  endfunction

  // Model of one capture on digit d: dedupe against shadow, drop when the FIFO is full.
  task automatic expect_cap(input int d, input logic [7:0] c, input logic e);
    if (!m_seen[d] || m_shadow[d] != c) begin
      if (ready || q.size() < 4) q.push_back('{idx: 4'(d), code: c, err: e});
    end
    m_seen[d]   = 1'b1;
    m_shadow[d] = c;
  endtask

  task automatic drive(input logic [DIGITS-1:0] a, input logic [6:0] s, input int hold);
    an  = a;
    seg = s;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input logic [7:0] c, input logic e);
    expect_cap(d, c, e);
    drive(an_for(d), s, 8);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < DIGITS; i++) begin
      m_seen[i]   = 1'b0;
      m_shadow[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an    = '1;
    seg   = '1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      ev_cnt++;
      chk("ev_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("ev_code", 32'(code), 32'(mon_e.code));
        chk("ev_idx", 32'(idx), 32'(mon_e.idx));
        chk("ev_err", 32'(err), 32'(mon_e.err));
      end
    end
    if (rst_n && frame) frame_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    int base;
    int fbase;

    rst_n = 1'b0;
    an    = '1;
    seg   = '1;
    ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First event latency: pins change before edge 0, event visible after edge 3+STABLE.
    expect_cap(0, 8'h00, 1'b0);
    an  = 8'b11111110;
    seg = 7'b1000000;
    for (int k = 0; k <= 3 + STABLE; k++) begin
      @(posedge clk);
      #1;
      if (k == 2 + STABLE) chk("lat_before", 32'(valid), 32'd0);
      if (k == 3 + STABLE) begin
        chk("lat_valid", 32'(valid), 32'd1);
        chk("lat_code", 32'(code), 32'h00);
        chk("lat_idx", 32'(idx), 32'd0);
        chk("lat_err", 32'(err), 32'd0);
      end
    end
    wait_drain();

    // Directed decode cases, including shared shape, blank and unknown pattern.
    show(1, 7'b0001000, 8'h0A, 1'b0);
    show(2, 7'b0111111, 8'h24, 1'b0);
    show(3, 7'b1111001, 8'h01, 1'b0);
    show(4, 7'b1111111, 8'h3E, 1'b0);
    show(5, 7'b0110110, 8'h3F, 1'b1);
    wait_drain();

    // Two identical scans: one event per digit, one frame pulse per scan.
    do_reset();
    base  = ev_cnt;
    fbase = frame_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < DIGITS; d++) begin
        m = m_decode(~glyph[d]);
        show(d, ~glyph[d], m[7:0], m[8]);
      end
    end
    wait_drain();
    chk("scan_events", 32'(ev_cnt - base), 32'd8);
    chk("scan_frames", 32'(frame_cnt - fbase), 32'd2);

    // Short glitch and multi-digit enables must not produce events.
    base = ev_cnt;
    drive(an_for(0), 7'b0001000, 2);
    drive(an_for(7), ~glyph[7], 12);
    drive(8'b11111100, 7'b0001000, 12);
    drive(an_for(7), ~glyph[7], 12);
    chk("glitch_events", 32'(ev_cnt - base), 32'd0);

    // Consumer stalled: five new glyphs, four queued, fifth dropped.
    ready = 1'b0;
    base  = ev_cnt;
    for (int d = 0; d < 5; d++) begin
      m = m_decode(~glyph[10 + d]);
      show(d, ~glyph[10 + d], m[7:0], m[8]);
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_valid", 32'(valid), 32'd1);
    chk("stall_code", 32'(code), 32'h0A);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold_code", 32'(code), 32'h0A);
    chk("stall_hold_idx", 32'(idx), 32'd0);
    ready = 1'b1;
    wait_drain();
    chk("ovf_events", 32'(ev_cnt - base), 32'd4);

    // Reset with three queued events, then the same glyph reappears as a fresh event.
    ready = 1'b0;
    for (int d = 5; d < 8; d++) begin
      m = m_decode(~glyph[10 + d]);
      show(d, ~glyph[10 + d], m[7:0], m[8]);
    end
    chk("prerst_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    clear_model();
    an  = '1;
    seg = '1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    base  = ev_cnt;
    m = m_decode(~glyph[15]);
    show(5, ~glyph[15], m[7:0], m[8]);
    wait_drain();
    chk("postrst_events", 32'(ev_cnt - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_sniff.md
SEGMENT_SNIFF -- requirements
Module: segment_sniff

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digit positions, 2..16.
REQ-002 SHALL have parameter STABLE, default 4: cycles the synchronized lines must hold before capture, 1..255.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: i_clk input 1, rising-edge clock; i_rst_n input 1, reset.
REQ-004 SHALL have port i_seg input 7: segment lines, active-low, bit0 top, 1 top-right, 2 bottom-right, 3 bottom, 4 bottom-left, 5 top-left, 6 middle.
REQ-005 SHALL have port i_an input DIGITS: digit enables, active-low.
REQ-006 SHALL have port o_code output 8: decoded character code, text glyph code space; bits [7:6] always 0.
REQ-007 SHALL have port o_idx output $clog2(DIGITS): digit position of o_code.
REQ-008 SHALL have port o_err output 1: o_code came from an unrecognised pattern.
REQ-009 SHALL have port o_valid output 1: event available.
REQ-010 SHALL have port i_ready input 1: consumer accepts the event.
REQ-011 SHALL have port o_frame output 1: one-cycle pulse when every digit has been captured since the last pulse.
REQ-012 SHALL have port o_ovf output 1: sticky, event dropped because the FIFO was full.

Function
REQ-013 SHALL pass i_seg and i_an through a 2-flop synchronizer before use.
REQ-014 SHALL run a stability counter: it clears to 0 when the synchronized {an,seg} differs from the previous cycle, and otherwise increments, saturating at STABLE.
REQ-015 SHALL run an FSM with states WAIT and HOLD: WAIT -> HOLD on the cycle the counter reaches STABLE; HOLD -> WAIT on any change of {an,seg}.
REQ-016 SHALL capture on the WAIT->HOLD transition only when exactly one i_an bit is 0; an all-high or multi-low i_an enters HOLD with no capture.
REQ-017 SHALL decode by inverting the team text glyph table, codes 'h00-'h24.
REQ-018 SHALL resolve shared glyph patterns to the digit code: 1/I -> 'h01, 0/O -> 'h00, 5/S -> 'h05, 2/Z -> 'h02.
REQ-019 SHALL map 'b1111111 (blank) to 'h3E with err=0, and any other unlisted pattern to 'h3F with err=1.
REQ-020 SHALL keep a per-digit shadow code register with a per-digit seen bit.
REQ-021 SHALL, on capture, write {idx,code,err} to the FIFO only if seen=0 or the code differs from the shadow, and SHALL then update the shadow and set seen.
REQ-022 SHALL use a 4-entry FIFO, first-word-fall-through: o_valid = not empty; the head entry drives o_code/o_idx/o_err; a pop occurs when o_valid and i_ready are both 1.
REQ-023 SHALL, when a write arrives with the FIFO full and no pop, drop the write and set o_ovf.
REQ-024 SHALL accept a write arriving with the FIFO full and a pop in the same cycle.
REQ-025 SHALL hold o_code/o_idx/o_err stable while o_valid=1 and i_ready=0.
REQ-026 SHALL keep a frame mask: each capture sets that digit's bit (whether written or not); when the mask becomes all-ones, o_frame pulses on the next cycle and the mask clears.
REQ-027 SHALL meet the latency: with pins changed before edge 0 and held, and the FIFO empty, o_valid rises after edge 3+STABLE.
REQ-028 SHALL treat a counter already at STABLE with unchanged lines as no new capture, so a static display produces exactly one capture per digit change.

Reset
REQ-029 SHALL, while i_rst_n=0, force: synchronizers to all-ones; counter 0; FSM WAIT; FIFO empty; seen, shadow and frame mask 0; o_valid, o_frame, o_ovf, o_err 0; o_code 0; o_idx 0.
REQ-030 SHALL discard FIFO contents and the in-progress count on reset mid-operation; the first capture after release is always written.

Verification
REQ-031 SHALL cover this directed case: STABLE=4; i_an='b11111110, i_seg='b1000000 held -> o_valid at edge 7, o_code='h00, o_idx=0, o_err=0.
REQ-032 SHALL cover these directed cases: i_seg 'b0001000 -> 'h0A; 'b0111111 -> 'h24; 'b1111001 -> 'h01 (never 'h12); 'b1111111 -> 'h3E; 'b0110110 -> 'h3F with o_err=1.
REQ-033 SHALL cover this directed case: scan 8 digits twice with identical glyphs -> exactly 8 events, and o_frame pulses twice (once per full scan).
REQ-034 SHALL cover this directed case: i_ready=0, 5 distinct changes -> 4 events queued, o_ovf=1; when drained, they come out in order.
REQ-035 SHALL cover this directed case: glitch shorter than STABLE, or two i_an bits low -> no event.
REQ-036 SHALL cover this directed case: assert i_rst_n=0 with the FIFO holding 3 entries -> o_valid=0 immediately; after release, the same glyph produces a fresh event.
